// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, Rcon, block type, FSM states and the
// byte-level round transforms used by the key schedule and the datapath.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_KEYEXP = 2'd0,
    ST_IDLE   = 2'd1,
    ST_BUSY   = 2'd2
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic block_t sub_bytes(input block_t b);
    block_t r;
    r = '0;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = sub_word(b[32*i +: 32]);
    return r;
  endfunction

  // Byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4.
  function automatic block_t shift_rows(input block_t b);
    block_t r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(row+4*c) -: 8] = b[127-8*(row+4*((c+row)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic block_t mix_columns(input block_t b);
    block_t r;
    r = '0;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = mix_column(b[32*c +: 32]);
    return r;
  endfunction

  function automatic block_t key_step(input block_t prev, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = prev;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes128_core.sv
// AES-128 core: sequential key schedule into 11 round-key registers, then
// an iterative one-round-per-clock encrypt datapath.
module aes128_core
  import aes_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_start,
  input  block_t i_plaintext,
  input  block_t i_key,
  output block_t o_ciphertext,
  output logic   o_accept,
  output logic   o_finish
);

  state_t     r_state;
  block_t     r_rk [11];
  block_t     r_data;
  block_t     r_ct;
  logic [3:0] r_kcnt;
  logic [3:0] r_round;
  logic       key_ready;

  logic [3:0] w_kidx;
  block_t     w_rk_next;
  block_t     w_sr;
  block_t     w_round_out;

  // Previous round-key index, clamped so it never leaves the array.
  always_comb begin
    w_kidx = 4'd0;
    if ((r_kcnt != 4'd0) && (r_kcnt <= 4'd10)) w_kidx = r_kcnt - 4'd1;
    else w_kidx = 4'd0;
  end

  assign w_rk_next   = key_step(r_rk[w_kidx], RCON[w_kidx]);
  assign w_sr        = shift_rows(sub_bytes(r_data));
  assign w_round_out = ((r_round == 4'd10) ? w_sr : mix_columns(w_sr)) ^ r_rk[r_round];

  assign o_accept     = (r_state == ST_IDLE) && i_start;
  assign o_finish     = (r_state == ST_BUSY) && (r_round == 4'd10);
  assign o_ciphertext = r_ct;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_KEYEXP;
      r_kcnt    <= 4'd0;
      r_round   <= 4'd0;
      r_data    <= '0;
      r_ct      <= '0;
      key_ready <= 1'b0;
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
    end else begin
      case (r_state)
        ST_KEYEXP: begin
          if (r_kcnt == 4'd0) r_rk[0] <= i_key;
          else r_rk[r_kcnt] <= w_rk_next;
          r_kcnt <= r_kcnt + 4'd1;
          if (r_kcnt == 4'd10) begin
            key_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (i_start) begin
            r_data  <= i_plaintext ^ r_rk[0];
            r_round <= 4'd1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_data  <= w_round_out;
          r_round <= r_round + 4'd1;
          // Final round: publish the result and park the round index at 0.
          if (r_round == 4'd10) begin
            r_ct    <= w_round_out;
            r_round <= 4'd0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_KEYEXP;
      endcase
    end
  end

endmodule

// File: rtl/aes_128_top.sv
// AES-128 encrypt engine top: wraps the core and owns the done policy.
// Define AES_DONE_STICKY_EN to hold done high until the next accepted start.
module aes_128_top
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic [127:0] ciphertext,
  output logic         done
);

`ifdef AES_DONE_STICKY_EN
  localparam bit DONE_STICKY = 1'b1;
`else
  localparam bit DONE_STICKY = 1'b0;
`endif

  logic w_accept;
  logic w_finish;
  logic r_done;

  aes128_core CORE (
    .clk          (clk),
    .rst          (reset),
    .i_start      (start),
    .i_plaintext  (plaintext),
    .i_key        (key),
    .o_ciphertext (ciphertext),
    .o_accept     (w_accept),
    .o_finish     (w_finish)
  );

  // Completion sets done; in sticky mode it holds until the next acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_finish | (DONE_STICKY & r_done & ~w_accept);
  end

  assign done = r_done;

endmodule

// File: tb/tb_aes_128_top.sv
// Self-checking bench for aes_128_top against a byte-array AES-128 model.
module tb_aes_128_top;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_DONE_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         done;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [7:0]   sb [256];

  aes_128_top dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .ciphertext (ciphertext),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Generic GF(2^8) multiply (shift-and-add, reduction by 0x11b).
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic void init_sbox();
    logic [7:0] inv, xb, yb;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      xb  = x[7:0];
      for (int y = 1; y < 256; y++) begin
        yb = y[7:0];
        if (gmul(xb, yb) == 8'h01) inv = yb;
      end
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, sw, a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        sw = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[sw];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4)+(i%4))%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    out = '0;
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // Reset, release with key k, and wait out the 11-edge expansion.
  task automatic reset_and_expand(input logic [127:0] k);
    reset = 1'b1;
    start = 1'b0;
    key   = k;
    tick();
    reset = 1'b0;
    tick();
    key = rand128();
    for (int i = 2; i <= 11; i++) tick();
    check("expand_ready", 128'(dut.CORE.key_ready), 128'h1);
  endtask

  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] exp,
                           input bit poke);
    logic seen = 1'b0;
    logic bad = 1'b0;
    start = 1'b1;
    plaintext = pt;
    tick();
    start = 1'b0;
    plaintext = rand128();
    for (int i = 1; i < 10; i++) begin
      if (poke && i == 4) start = 1'b1;
      else start = 1'b0;
      tick();
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "_early_done"}, 128'(seen), 128'h0);
    tick();
    check({tag, "_done"}, 128'(done), 128'h1);
    check({tag, "_ct"}, ciphertext, exp);
    tick();
    check({tag, "_after"}, 128'(done), 128'(STICKY));
    if (poke) begin
      for (int i = 0; i < 11; i++) begin
        tick();
        if (done !== STICKY || ciphertext !== exp) bad = 1'b1;
      end
      check({tag, "_no_second"}, 128'(bad), 128'h0);
    end
  endtask

  initial begin
    logic seen;
    logic [127:0] pt, exp;
    init_sbox();
    reset = 1'b1; start = 1'b0; plaintext = '0; key = KEY_C1;
    tick(); tick();
    check("rst_ct", ciphertext, 128'h0);
    check("rst_done", 128'(done), 128'h0);
    check("rst_key_ready", 128'(dut.CORE.key_ready), 128'h0);

    // Start before ready, then key changed after capture.
    reset = 1'b0;
    tick();
    key = rand128();
    tick();
    start = 1'b1; plaintext = rand128();
    tick();
    start = 1'b0;
    for (int i = 4; i <= 10; i++) tick();
    check("kr_edge10", 128'(dut.CORE.key_ready), 128'h0);
    tick();
    check("kr_edge11", 128'(dut.CORE.key_ready), 128'h1);
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("early_start_done", 128'(seen), 128'h0);
    check("early_start_ct", ciphertext, 128'h0);

    run_block("c1", PT_C1, CT_C1, 1'b0);
    run_block("busy", PT_C1, CT_C1, 1'b1);
    for (int n = 0; n < 4; n++) begin
      pt = rand128();
      run_block("rnd_c1", pt, model_encrypt(KEY_C1, pt), 1'b0);
    end

    // Back-to-back with start held high.
    start = 1'b1;
    for (int n = 0; n < 4; n++) begin
      pt = rand128();
      exp = model_encrypt(KEY_C1, pt);
      plaintext = pt;
      tick();
      check("b2b_clear", 128'(done), 128'h0);
      plaintext = rand128();
      seen = 1'b0;
      for (int i = 1; i < 10; i++) begin
        tick();
        if (done) seen = 1'b1;
      end
      check("b2b_early", 128'(seen), 128'h0);
      tick();
      check("b2b_done", 128'(done), 128'h1);
      check("b2b_ct", ciphertext, exp);
    end
    start = 1'b0;
    tick();

    // Reset in the middle of round 5.
    start = 1'b1; plaintext = PT_C1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    key = KEY_C1;
    #1;
    check("midrst_ct", ciphertext, 128'h0);
    check("midrst_done", 128'(done), 128'h0);
    check("midrst_kr", 128'(dut.CORE.key_ready), 128'h0);
    reset_and_expand(KEY_C1);
    run_block("c1_again", PT_C1, CT_C1, 1'b0);

    reset_and_expand(KEY_B);
    run_block("fipsB", PT_B, CT_B, 1'b0);

    for (int n = 0; n < 3; n++) begin
      logic [127:0] k;
      k = rand128();
      reset_and_expand(k);
      for (int m = 0; m < 2; m++) begin
        pt = rand128();
        run_block("rnd_key", pt, model_encrypt(k, pt), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
